// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle controller:
//   - FSM state codes (legacy-compatible localparam constants)
//   - opcode / R-type func field constants
//   - ALU operation codes and datapath mux encodings
//   - ctrl_t: the bundle of datapath strobes driven each cycle
//   - decode helper functions for the ALU operation
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

  // FSM state codes
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH  = 4'd0;
  localparam state_t S_DECODE = 4'd1;
  localparam state_t S_EXEC   = 4'd2;
  localparam state_t S_MEM    = 4'd3;
  localparam state_t S_WB     = 4'd4;
  localparam state_t S_BRANCH = 4'd5;
  localparam state_t S_JUMP   = 4'd6;
  localparam state_t S_LINK   = 4'd7;
  localparam state_t S_HALT   = 4'd8;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LI    = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type func field
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_OR  = 6'b011000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Next-PC source
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_JR     = 2'b11;

  // Register-file destination
  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  // ALU B operand source
  localparam logic [1:0] ALUB_RT   = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;

  // Datapath strobes produced by the FSM each cycle
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctr;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // True for every R-type func that executes through EXEC (jr is handled apart)
  function automatic logic rfunc_known(input logic [5:0] fn);
    logic known;
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR,
      FN_SLT, FN_SLL, FN_SRL:          known = 1'b1;
      default:                          known = 1'b0;
    endcase
    return known;
  endfunction

  // ALU operation for an R-type instruction
  function automatic logic [2:0] rfunc_alu(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      FN_SLL:  op = ALU_SLL;
      FN_SRL:  op = ALU_SRL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // ALU operation for an immediate-form instruction (addi/li/lw/sw use add)
  function automatic logic [2:0] imm_alu(input logic [5:0] opc);
    logic [2:0] op;
    case (opc)
      OP_ANDI: op = ALU_AND;
      OP_ORI:  op = ALU_OR;
      OP_SLTI: op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_watchdog.sv
// -----------------------------------------------------------------------------
// mc_watchdog
// Counts consecutive cycles in which a memory request is pending without a
// ready response. expired is raised combinationally in the cycle the count
// reaches TIMEOUT; a ready response in that same cycle suppresses it.
// TIMEOUT = 0 disables the watchdog (expired is constant 0).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : memory request currently asserted
//   ready      : memory access complete this cycle
//   clear      : FSM is changing state this cycle (restart the count)
//   expired    : wait limit reached this cycle
// -----------------------------------------------------------------------------
module mc_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // count_r holds the number of waiting cycles already elapsed, so the
  // TIMEOUT-th waiting cycle is the one seen with count_r == TIMEOUT-1.
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic EN = (TIMEOUT > 0);

  logic [CNT_W-1:0] count_r;
  logic             waiting_s;

  assign waiting_s = req & ~ready;
  assign expired   = EN & waiting_s & (count_r == LIMIT);

  // Waiting-cycle counter; restarts whenever the wait is broken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear || !waiting_s || expired) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_r + CNT_W'(1'b1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multicycle MIPS-style control FSM: FETCH, DECODE, EXEC, MEM, WB, BRANCH,
// JUMP, LINK, HALT. Strobes are decoded from the current state (plus
// mem_ready/alu_zero where the transfer depends on them) and are forced to 0
// while in reset and during the first cycle after reset release, so the
// first fetch request appears on the first clk edge after rst_n deasserts.
// Optional build macro: JAL_LINK_EN -- when defined, jal goes through LINK
// (writes r31 and jumps); when undefined, jal behaves exactly like j.
// Parameters: ALUCTR_W (ALU control width), TIMEOUT (memory-wait limit, 0 off)
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   op_code, func         : instruction fields from the IR
//   alu_zero, mem_ready   : datapath / memory status
//   mem_req, mem_we, iord : memory interface control
//   ir_write, pc_write, pc_src : IR / PC load control
//   reg_wr, reg_dst, mem_to_reg : register-file write control
//   alu_src_a, alu_src_b, alu_ctr : ALU operand and operation select
//   halted, illegal, mem_timeout  : sticky status flags
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int ALUCTR_W = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op_code,
  input  logic [5:0]          func,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_wr,
  output logic [1:0]          reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic                halted,
  output logic                illegal,
  output logic                mem_timeout
);

  import multicycle_control_pkg::*;

  state_t     state_r;
  state_t     decode_next_s;
  state_t     state_next_s;
  logic [5:0] op_r;
  logic [5:0] func_r;
  logic       active_r;
  logic       halted_r;
  logic       illegal_r;
  logic       mem_timeout_r;
  logic       illegal_set_s;
  logic       wd_expired_s;
  logic       wd_clear_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;

  // Per-state strobe decode and normal next-state selection
  always_comb begin
    ctrl_s        = CTRL_IDLE;
    decode_next_s = state_r;
    illegal_set_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_req   = 1'b1;
        ctrl_s.alu_src_b = ALUB_FOUR;
        ctrl_s.alu_ctr   = ALU_ADD;
        if (mem_ready) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
          ctrl_s.pc_src   = PC_SRC_SEQ;
          decode_next_s   = S_DECODE;
        end else begin
          decode_next_s   = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op_code)
          OP_RTYPE: begin
            if (func == FN_JR) begin
              decode_next_s = S_JUMP;
            end else if (rfunc_known(func)) begin
              decode_next_s = S_EXEC;
            end else begin
              decode_next_s = S_HALT;
              illegal_set_s = 1'b1;
            end
          end
          OP_ANDI, OP_ORI, OP_ADDI, OP_SLTI,
          OP_LI, OP_LW, OP_SW:              decode_next_s = S_EXEC;
          OP_BEQ, OP_BNE:                   decode_next_s = S_BRANCH;
          OP_J:                             decode_next_s = S_JUMP;
`ifdef JAL_LINK_EN
          OP_JAL:                           decode_next_s = S_LINK;
`else
          OP_JAL:                           decode_next_s = S_JUMP;
`endif
          default: begin
            decode_next_s = S_HALT;
            illegal_set_s = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        if (op_r == OP_RTYPE) begin
          ctrl_s.alu_src_b = ALUB_RT;
          ctrl_s.alu_ctr   = rfunc_alu(func_r);
        end else begin
          ctrl_s.alu_src_b = ALUB_IMM;
          ctrl_s.alu_ctr   = imm_alu(op_r);
        end
        if ((op_r == OP_LW) || (op_r == OP_SW)) begin
          decode_next_s = S_MEM;
        end else begin
          decode_next_s = S_WB;
        end
      end
      S_MEM: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.iord    = 1'b1;
        ctrl_s.mem_we  = (op_r == OP_SW);
        if (!mem_ready) begin
          decode_next_s = S_MEM;
        end else if (op_r == OP_SW) begin
          decode_next_s = S_FETCH;
        end else begin
          decode_next_s = S_WB;
        end
      end
      S_WB: begin
        ctrl_s.reg_wr     = 1'b1;
        ctrl_s.reg_dst    = (op_r == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
        ctrl_s.mem_to_reg = (op_r == OP_LW);
        decode_next_s     = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_s.alu_ctr   = ALU_SUB;
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = ALUB_RT;
        ctrl_s.pc_src    = PC_SRC_BRANCH;
        // beq takes the branch on equal operands, bne on unequal ones
        ctrl_s.pc_write  = (op_r == OP_BEQ) ? alu_zero : ~alu_zero;
        decode_next_s    = S_FETCH;
      end
      S_JUMP: begin
        ctrl_s.pc_write = 1'b1;
        ctrl_s.pc_src   = (op_r == OP_RTYPE) ? PC_SRC_JR : PC_SRC_JUMP;
        decode_next_s   = S_FETCH;
      end
      S_LINK: begin
`ifdef JAL_LINK_EN
        // PC already holds PC+4 from FETCH; it is routed through the A path
        ctrl_s.reg_wr    = 1'b1;
        ctrl_s.reg_dst   = REG_DST_R31;
        ctrl_s.alu_src_a = 1'b0;
        ctrl_s.alu_src_b = ALUB_RT;
        ctrl_s.pc_write  = 1'b1;
        ctrl_s.pc_src    = PC_SRC_JUMP;
        decode_next_s    = S_FETCH;
`else
        // Unreachable in this build; park safely
        decode_next_s    = S_HALT;
`endif
      end
      S_HALT: begin
        decode_next_s = S_HALT;
      end
      default: begin
        // Corrupted state code: stop rather than run wild
        decode_next_s = S_HALT;
      end
    endcase
  end

  // Strobes are held off until the cycle after reset release
  always_comb begin
    if (active_r) begin
      ctrl_out_s = ctrl_s;
    end else begin
      ctrl_out_s = CTRL_IDLE;
    end
  end

  // Final next state: idle hold before start-up, watchdog overrides decode
  always_comb begin
    if (!active_r) begin
      state_next_s = state_r;
    end else if (wd_expired_s) begin
      state_next_s = S_HALT;
    end else begin
      state_next_s = decode_next_s;
    end
  end

  assign wd_clear_s = (decode_next_s != state_r);

  mc_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ctrl_out_s.mem_req),
    .ready   (mem_ready),
    .clear   (wd_clear_s),
    .expired (wd_expired_s)
  );

  // Start-up flag: first edge after reset release enables the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
    end else begin
      active_r <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture the instruction fields while decoding for use in later states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= 6'b000000;
      func_r <= 6'b000000;
    end else if (state_r == S_DECODE) begin
      op_r   <= op_code;
      func_r <= func;
    end else begin
      op_r   <= op_r;
      func_r <= func_r;
    end
  end

  // Sticky status flags; cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_r      <= 1'b0;
      illegal_r     <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      halted_r      <= halted_r | (state_next_s == S_HALT);
      illegal_r     <= illegal_r | (illegal_set_s & active_r);
      mem_timeout_r <= mem_timeout_r | wd_expired_s;
    end
  end

  assign mem_req     = ctrl_out_s.mem_req;
  assign mem_we      = ctrl_out_s.mem_we;
  assign iord        = ctrl_out_s.iord;
  assign ir_write    = ctrl_out_s.ir_write;
  assign pc_write    = ctrl_out_s.pc_write;
  assign pc_src      = ctrl_out_s.pc_src;
  assign reg_wr      = ctrl_out_s.reg_wr;
  assign reg_dst     = ctrl_out_s.reg_dst;
  assign mem_to_reg  = ctrl_out_s.mem_to_reg;
  assign alu_src_a   = ctrl_out_s.alu_src_a;
  assign alu_src_b   = ctrl_out_s.alu_src_b;
  assign alu_ctr     = ALUCTR_W'(ctrl_out_s.alu_ctr);
  assign halted      = halted_r;
  assign illegal     = illegal_r;
  assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed, cycle-exact bench for multicycle_control. Each cycle the expected
// strobe/flag snapshot is pushed to a scoreboard queue, then popped and
// compared against the DUT mid-cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op_code;
  logic [5:0] func;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic       mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctr;
  logic       halted, illegal, mem_timeout;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctr;
    logic       halted;
    logic       illegal;
    logic       mem_timeout;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  multicycle_control #(
    .ALUCTR_W (3),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_code     (op_code),
    .func        (func),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_wr      (reg_wr),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_ctr     (alu_ctr),
    .halted      (halted),
    .illegal     (illegal),
    .mem_timeout (mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected snapshots, written from the behaviour of each state
  function automatic exp_t e_fetch(input logic rdy);
    exp_t e = '0;
    e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.alu_ctr = 3'b000;
    if (rdy) begin e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b00; end
    return e;
  endfunction

  function automatic exp_t e_exec(input logic rtype, input logic [2:0] ctr);
    exp_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = rtype ? 2'b00 : 2'b10; e.alu_ctr = ctr;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic sw);
    exp_t e = '0;
    e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = sw;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic rtype, input logic lw);
    exp_t e = '0;
    e.reg_wr = 1'b1; e.reg_dst = rtype ? 2'b01 : 2'b00; e.mem_to_reg = lw;
    return e;
  endfunction

  function automatic exp_t e_branch(input logic pw);
    exp_t e = '0;
    e.alu_ctr = 3'b001; e.alu_src_a = 1'b1; e.alu_src_b = 2'b00;
    e.pc_src = 2'b01; e.pc_write = pw;
    return e;
  endfunction

  function automatic exp_t e_jump(input logic jr);
    exp_t e = '0;
    e.pc_write = 1'b1; e.pc_src = jr ? 2'b11 : 2'b10;
    return e;
  endfunction

  function automatic exp_t e_link();
    exp_t e = '0;
    e.reg_wr = 1'b1; e.reg_dst = 2'b10; e.pc_write = 1'b1; e.pc_src = 2'b10;
    return e;
  endfunction

  function automatic exp_t e_halt(input logic ill, input logic to);
    exp_t e = '0;
    e.halted = 1'b1; e.illegal = ill; e.mem_timeout = to;
    return e;
  endfunction

  // Compare current DUT outputs with the oldest scoreboard entry
  task automatic chk(input string tag, input exp_t e);
    exp_t obs;
    exp_t want;
    sb_q.push_back(e);
    obs = '0;
    obs.mem_req = mem_req;     obs.mem_we = mem_we;         obs.iord = iord;
    obs.ir_write = ir_write;   obs.pc_write = pc_write;     obs.pc_src = pc_src;
    obs.reg_wr = reg_wr;       obs.reg_dst = reg_dst;       obs.mem_to_reg = mem_to_reg;
    obs.alu_src_a = alu_src_a; obs.alu_src_b = alu_src_b;   obs.alu_ctr = alu_ctr;
    obs.halted = halted;       obs.illegal = illegal;       obs.mem_timeout = mem_timeout;
    want = sb_q.pop_front();
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One clock cycle: apply this cycle's inputs just after the edge, then check
  task automatic cyc(input string tag, input exp_t e, input logic rdy, input logic z);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    alu_zero  = z;
    #1;
    chk(tag, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_hold", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release", '0);
  endtask

  logic [5:0] t_op  [13];
  logic [5:0] t_fn  [13];
  logic       t_rt  [13];
  logic [2:0] t_ctr [13];

  initial begin
    #100000;
    $display("FAIL bench_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; op_code = 6'b000000; func = 6'b000000;
    alu_zero = 1'b0; mem_ready = 1'b1;

    t_op[0]  = 6'b000000; t_fn[0]  = 6'b100000; t_rt[0]  = 1'b1; t_ctr[0]  = 3'b000;
    t_op[1]  = 6'b000000; t_fn[1]  = 6'b100010; t_rt[1]  = 1'b1; t_ctr[1]  = 3'b001;
    t_op[2]  = 6'b000000; t_fn[2]  = 6'b100100; t_rt[2]  = 1'b1; t_ctr[2]  = 3'b100;
    t_op[3]  = 6'b000000; t_fn[3]  = 6'b011000; t_rt[3]  = 1'b1; t_ctr[3]  = 3'b101;
    t_op[4]  = 6'b000000; t_fn[4]  = 6'b101010; t_rt[4]  = 1'b1; t_ctr[4]  = 3'b110;
    t_op[5]  = 6'b000000; t_fn[5]  = 6'b000000; t_rt[5]  = 1'b1; t_ctr[5]  = 3'b011;
    t_op[6]  = 6'b000000; t_fn[6]  = 6'b000010; t_rt[6]  = 1'b1; t_ctr[6]  = 3'b111;
    t_op[7]  = 6'b001100; t_fn[7]  = 6'b111111; t_rt[7]  = 1'b0; t_ctr[7]  = 3'b100;
    t_op[8]  = 6'b001101; t_fn[8]  = 6'b000000; t_rt[8]  = 1'b0; t_ctr[8]  = 3'b101;
    t_op[9]  = 6'b001010; t_fn[9]  = 6'b000000; t_rt[9]  = 1'b0; t_ctr[9]  = 3'b110;
    t_op[10] = 6'b001000; t_fn[10] = 6'b100010; t_rt[10] = 1'b0; t_ctr[10] = 3'b000;
    t_op[11] = 6'b000001; t_fn[11] = 6'b000000; t_rt[11] = 1'b0; t_ctr[11] = 3'b000;
    t_op[12] = 6'b000000; t_fn[12] = 6'b100000; t_rt[12] = 1'b1; t_ctr[12] = 3'b000;

    // Reset state: everything low while rst_n is held
    #12;
    chk("reset_state", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("pre_first_edge", '0);

    // ALU-type instructions: FETCH, DECODE, EXEC, WB (4 cycles each)
    for (int i = 0; i < 13; i++) begin
      op_code = t_op[i]; func = t_fn[i];
      cyc("alu_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
      cyc("alu_decode", '0, 1'b1, 1'b0);
      cyc("alu_exec",   e_exec(t_rt[i], t_ctr[i]), 1'b1, 1'b0);
      cyc("alu_wb",     e_wb(t_rt[i], 1'b0), 1'b1, 1'b0);
    end

    // lw with memory stalled for 3 cycles in MEM
    op_code = 6'b100011; func = 6'b000000;
    cyc("lw_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
    cyc("lw_decode", '0, 1'b1, 1'b0);
    cyc("lw_exec",   e_exec(1'b0, 3'b000), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc("lw_mem_wait", e_mem(1'b0), 1'b0, 1'b0);
    cyc("lw_mem_done", e_mem(1'b0), 1'b1, 1'b0);
    cyc("lw_wb",     e_wb(1'b0, 1'b1), 1'b1, 1'b0);

    // sw: 4 cycles, write strobe in MEM
    op_code = 6'b101011;
    cyc("sw_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
    cyc("sw_decode", '0, 1'b1, 1'b0);
    cyc("sw_exec",   e_exec(1'b0, 3'b000), 1'b1, 1'b0);
    cyc("sw_mem",    e_mem(1'b1), 1'b1, 1'b0);

    // Branches: all four combinations of beq/bne and alu_zero
    for (int b = 0; b < 4; b++) begin
      op_code = (b < 2) ? 6'b000100 : 6'b000101;
      cyc("br_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
      cyc("br_decode", '0, 1'b1, 1'b0);
      cyc("br_exec", e_branch((b < 2) ? (b == 0) : (b == 3)), 1'b1, (b == 0 || b == 2));
    end

    // j and jr
    op_code = 6'b000010;
    cyc("j_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
    cyc("j_decode", '0, 1'b1, 1'b0);
    cyc("j_jump",   e_jump(1'b0), 1'b1, 1'b0);
    op_code = 6'b000000; func = 6'b001000;
    cyc("jr_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
    cyc("jr_decode", '0, 1'b1, 1'b0);
    cyc("jr_jump",   e_jump(1'b1), 1'b1, 1'b0);

    // jal
    op_code = 6'b000011; func = 6'b000000;
    cyc("jal_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
    cyc("jal_decode", '0, 1'b1, 1'b0);
`ifdef JAL_LINK_EN
    cyc("jal_link",   e_link(), 1'b1, 1'b0);
`else
    cyc("jal_jump",   e_jump(1'b0), 1'b1, 1'b0);
`endif

    // Watchdog boundary: ready arrives in the 16th waiting cycle, no timeout
    op_code = 6'b000010;
    for (int k = 0; k < 15; k++) cyc("wd_edge_wait", e_fetch(1'b0), 1'b0, 1'b0);
    cyc("wd_edge_ready", e_fetch(1'b1), 1'b1, 1'b0);
    cyc("wd_edge_decode", '0, 1'b1, 1'b0);
    cyc("wd_edge_jump",   e_jump(1'b0), 1'b1, 1'b0);

    // Illegal opcode halts with illegal set, sticky until reset
    op_code = 6'b111111;
    cyc("ill_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
    cyc("ill_decode", '0, 1'b1, 1'b0);
    cyc("ill_halt",   e_halt(1'b1, 1'b0), 1'b1, 1'b0);
    cyc("ill_halt2",  e_halt(1'b1, 1'b0), 1'b1, 1'b0);
    do_reset();

    // Illegal R-type func
    op_code = 6'b000000; func = 6'b111111;
    cyc("illfn_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
    cyc("illfn_decode", '0, 1'b1, 1'b0);
    cyc("illfn_halt",   e_halt(1'b1, 1'b0), 1'b1, 1'b0);
    do_reset();

    // Memory never ready in FETCH: 16 waiting cycles, then HALT with timeout
    for (int k = 0; k < 16; k++) cyc("to_wait", e_fetch(1'b0), 1'b0, 1'b0);
    cyc("to_halt",  e_halt(1'b0, 1'b1), 1'b1, 1'b0);
    cyc("to_halt2", e_halt(1'b0, 1'b1), 1'b1, 1'b0);
    cyc("to_halt3", e_halt(1'b0, 1'b1), 1'b0, 1'b0);
    do_reset();

    // Reset asserted in the middle of a pending fetch drops mem_req at once
    for (int k = 0; k < 3; k++) cyc("mid_wait", e_fetch(1'b0), 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_release", '0);
    op_code = 6'b000000; func = 6'b100000;
    cyc("after_fetch",  e_fetch(1'b1), 1'b1, 1'b0);
    cyc("after_decode", '0, 1'b1, 1'b0);
    cyc("after_exec",   e_exec(1'b1, 3'b000), 1'b1, 1'b0);
    cyc("after_wb",     e_wb(1'b1, 1'b0), 1'b1, 1'b0);
    cyc("after_fetch2", e_fetch(1'b1), 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
